// File: rtl/adc_sampler.sv
// adc_sampler: periodic 12-bit conversion reader for a null-bit framed SPI ADC.
// A free-running period counter issues a start tick every SAMPLE_PERIOD clocks.
// The FSM frames one 15-bit SPI read and publishes D11..D0 on sample with a
// one-cycle sample_valid strobe. A tick that arrives mid-conversion raises
// overrun and is otherwise ignored.
// Optional feature: define ADC_BIPOLAR_EN to invert D11, which turns the
// offset-binary code into two's complement (0x800 -> 0x000).
module adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1134
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]    BIT_LAST = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] period_cnt;
  logic          tick;
  logic [CW-1:0] div_cnt, div_cnt_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  // Only the last 12 captured bits are kept: the two sample clocks and the
  // null bit are shifted out of the top before the frame ends.
  logic [11:0]   shreg, shreg_d;
  logic [11:0]   conv_word;
  logic          cs_n_d, sclk_d, valid_d, overrun_d;
  logic [11:0]   sample_d;

  assign tick = (period_cnt == PER_LAST);

`ifdef ADC_BIPOLAR_EN
  assign conv_word = {~shreg[11], shreg[10:0]};
`else
  assign conv_word = shreg;
`endif

  // Free-running period counter; never stalls, even during a conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // State, counters, shift register and all outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      div_cnt      <= div_cnt_d;
      bit_cnt      <= bit_cnt_d;
      shreg        <= shreg_d;
      adc_cs_n     <= cs_n_d;
      adc_sclk     <= sclk_d;
      sample       <= sample_d;
      sample_valid <= valid_d;
      overrun      <= overrun_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so the registered pins line up with the state they belong to.
  always_comb begin
    state_d   = state;
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    cs_n_d    = 1'b1;
    sclk_d    = 1'b0;
    valid_d   = 1'b0;
    sample_d  = sample;
    overrun_d = tick && (state != IDLE);

    unique case (state)
      IDLE: begin
        if (tick) begin
          state_d   = SETUP;
          div_cnt_d = '0;
          cs_n_d    = 1'b0;
        end
      end

      SETUP: begin
        cs_n_d = 1'b0;
        if (div_cnt == DIV_LAST) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end

      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = adc_sclk;
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          if (!adc_sclk) begin
            // Rising SCLK edge: the ADC has held this bit since the last fall.
            sclk_d  = 1'b1;
            shreg_d = {shreg[10:0], adc_miso};
          end else if (bit_cnt == BIT_LAST) begin
            state_d  = DONE;
            sclk_d   = 1'b0;
            cs_n_d   = 1'b1;
            valid_d  = 1'b1;
            sample_d = conv_word;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/adc_sampler.md
# adc_sampler

Upstream capture stage for the pedal's audio path. It periodically reads one 12-bit conversion from an external SPI ADC (null-bit framed, MSB first). It presents each result on `sample` with a one-cycle `sample_valid` strobe. `sample_valid` drives the `update` input of the downstream convolution stage, and `sample` feeds its `A` operand.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; legal range ≥1.
- `SAMPLE_PERIOD`, default 1134: `clk` cycles between conversion starts; legal range ≥2.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `adc_miso`  in  1: ADC serial data. Already synchronous to `clk`; the board adds a 2-flop sync outside this block.
- `adc_cs_n`  out  1: ADC chip select, active low.
- `adc_sclk`  out  1: ADC serial clock. Idles low.
- `sample`  out  12: last completed conversion.
- `sample_valid`  out  1: one-cycle pulse when `sample` is updated.
- `overrun`  out  1: one-cycle pulse when a start tick arrives while a conversion is in flight.

## Operation
- **Reset values:** `adc_cs_n`=1, `adc_sclk`=0, `sample`=0, `sample_valid`=0, `overrun`=0. Period counter=0. FSM=IDLE. Shift register=0.
- **Period counter:**
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - `tick` asserts when counter==SAMPLE_PERIOD-1.
  - The first tick therefore occurs SAMPLE_PERIOD cycles after reset release.
- **FSM: IDLE → SETUP → SHIFT → DONE → IDLE.**
  - IDLE: `adc_cs_n`=1, `adc_sclk`=0. On `tick`, go to SETUP.
  - SETUP: `adc_cs_n`=0, `adc_sclk`=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 15 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
    - `adc_miso` is sampled in the `clk` cycle where registered `adc_sclk` goes 0→1 and is shifted into a 15-bit register MSB-first.
    - The first 3 bits (2 sample-clocks + null bit) are discarded.
    - Bits 4..15 are D11..D0.
    - After the 15th high phase ends, go to DONE.
  - DONE (one cycle): `adc_cs_n`=1, `adc_sclk`=0. `sample` ← D11..D0, optionally transformed (see Configuration). `sample_valid`=1. Next state is IDLE.
- **Overrun:**
  - A `tick` while FSM≠IDLE pulses `overrun` for that cycle and is otherwise ignored.
  - The in-flight conversion continues unaffected.
  - The period counter never stalls.
- **Simultaneous DONE and `tick`:** the tick counts as overrun. The FSM is not IDLE in that cycle, so no back-to-back start occurs.
- **Output hold:** `sample` holds its value between DONE cycles.
- **Reset mid-conversion:** all state returns to reset values immediately (asynchronous). `adc_cs_n` rises with no partial `sample_valid`. The period counter restarts from 0.

## Timing
- All outputs are registered; no combinational path from `adc_miso` to any output.
- If `tick` is high in cycle T, then:
  - `adc_cs_n` falls at T+1.
  - First `adc_sclk` rise at T+1+2·CLK_DIV.
  - `sample_valid` is high in cycle T+1+31·CLK_DIV, with `adc_cs_n` rising in that same cycle.
- Conversion length, `adc_cs_n` low: 31·CLK_DIV cycles.
  - SAMPLE_PERIOD < 31·CLK_DIV+2 guarantees recurring overrun.
  - This is legal but is a system configuration error.
- `adc_sclk` duty: exactly 50%. Frequency = f_clk/(2·CLK_DIV).
- The ADC drives `adc_miso` on SCLK falling edges, so data is stable by the rising-edge capture.

## Configuration
- `ADC_BIPOLAR_EN`
  - Defined: `sample` = {~D11, D10..D0}, converting offset-binary to two's complement. Mid-scale 0x800 → 0x000.
  - Undefined: `sample` = D11..D0 unchanged (unsigned).
- No other behaviour differs.

## Test plan
Bench uses CLK_DIV=2, SAMPLE_PERIOD=100, and an ADC model that drives `adc_miso` on each SCLK falling edge.
1. **Reset values and first tick:** hold `reset_n`=0, then release. All outputs read their reset values; `adc_cs_n` falls exactly 100 cycles after release.
2. **Basic conversion:** ADC model sends 0,0,0 then 0xA5C. `sample_valid` pulses once at cs_n fall + 62 cycles with `sample`=0xA5C; `adc_sclk` shows exactly 15 rising edges.
3. **`ADC_BIPOLAR_EN` defined:** same stimulus as scenario 2 gives `sample`=0x25C; model word 0x800 gives 0x000.
4. **Overrun:** rebuild with SAMPLE_PERIOD=40. `overrun` pulses once per conversion; every conversion still completes with correct data; no extra `adc_cs_n` fall occurs during a conversion.
5. **Reset mid-SHIFT:** assert `reset_n` after 6 SCLK rises. `adc_cs_n`=1 and `adc_sclk`=0 asynchronously; no `sample_valid`; `sample`=0; next conversion starts 100 cycles after release.
6. **Back-to-back conversions:** ADC model sends 0xFFF then 0x001. Consecutive `sample_valid` pulses are exactly 100 cycles apart, with values 0xFFF then 0x001.
